// File: rtl/uart_tx_fifo_engine.sv
// uart_tx_fifo_engine
//   UART transmitter with an internal TX FIFO. Bytes pushed by the register
//   block are framed (start, DATA_BITS LSB first, optional parity, 1 or 2
//   stops) and sent back-to-back with no per-bit CPU involvement.
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   i_wr_en        push i_wr_data into the FIFO this cycle
//   i_wr_data      frame payload (DATA_BITS)
//   i_flush        discard queued entries (the frame in flight continues)
//   i_clr_overflow clear the sticky overflow flag
//   o_tx           registered serial line, idle high
//   o_busy         a frame is on the line
//   o_full         FIFO holds FIFO_DEPTH entries
//   o_empty        FIFO holds no entries
//   o_count        entries queued
//   o_overflow     sticky: a write was dropped because the FIFO was full
module uart_tx_fifo_engine #(
  parameter int CLK_FREQ_HZ = 20_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_wr_en,
  input  logic [DATA_BITS-1:0]          i_wr_data,
  input  logic                          i_flush,
  input  logic                          i_clr_overflow,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(2 * CLKS_PER_BIT);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 overflow_q;
  logic                 wr_ok;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // Transmit engine
  state_t               state, state_nxt;
  logic [CW-1:0]        baud_cnt, baud_cnt_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 par_q, par_nxt;
  logic                 tx_q, tx_nxt;

  assign o_full     = (count == DEPTH_CNT);
  assign o_empty    = (count == '0);
  assign o_count    = count;
  assign o_overflow = overflow_q;
  assign o_tx       = tx_q;
  assign o_busy     = (state != S_IDLE);

  // A write racing a flush is discarded along with the queue.
  assign wr_ok = i_wr_en && !o_full && !i_flush;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      // A pop in this cycle has already captured the head; dropping the
      // rest just means catching the read pointer up to the write pointer.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                overflow_q <= 1'b0;
    else if (i_wr_en && o_full)  overflow_q <= 1'b1;
    else if (i_clr_overflow)     overflow_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
      par_q    <= par_nxt;
      tx_q     <= tx_nxt;
    end
  end

  // tx_nxt is the line level for the state being entered, so the line is
  // a flop output and changes exactly on bit boundaries.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    shreg_nxt    = shreg;
    par_nxt      = par_q;
    tx_nxt       = tx_q;
    pop          = 1'b0;

    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (!o_empty) begin
          pop          = 1'b1;
          shreg_nxt    = head;
          par_nxt      = (^head) ^ PAR_ODD;
          baud_cnt_nxt = BIT_LAST;
          tx_nxt       = 1'b0;
          state_nxt    = S_START;
        end
      end

      S_START: begin
        if (baud_cnt == '0) begin
          baud_cnt_nxt = BIT_LAST;
          bit_idx_nxt  = '0;
          tx_nxt       = shreg[0];
          shreg_nxt    = shreg >> 1;
          state_nxt    = S_DATA;
        end else begin
          baud_cnt_nxt = baud_cnt - CW'(1);
        end
      end

      S_DATA: begin
        if (baud_cnt == '0) begin
          baud_cnt_nxt = BIT_LAST;
          if (bit_idx == DATA_LAST) begin
            if (PAR_ON) begin
              tx_nxt    = par_q;
              state_nxt = S_PARITY;
            end else begin
              tx_nxt       = 1'b1;
              baud_cnt_nxt = STOP_LAST;
              state_nxt    = S_STOP;
            end
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = shreg[0];
            shreg_nxt   = shreg >> 1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt - CW'(1);
        end
      end

      S_PARITY: begin
        if (baud_cnt == '0) begin
          tx_nxt       = 1'b1;
          baud_cnt_nxt = STOP_LAST;
          state_nxt    = S_STOP;
        end else begin
          baud_cnt_nxt = baud_cnt - CW'(1);
        end
      end

      S_STOP: begin
        if (baud_cnt == '0) begin
          if (!o_empty) begin
            pop          = 1'b1;
            shreg_nxt    = head;
            par_nxt      = (^head) ^ PAR_ODD;
            baud_cnt_nxt = BIT_LAST;
            tx_nxt       = 1'b0;
            state_nxt    = S_START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          baud_cnt_nxt = baud_cnt - CW'(1);
        end
      end

      default: begin
        tx_nxt    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// tb_uart_tx_fifo_engine
//   Four transmitter configurations (8N1, 8E1, 8O1, 7N2; 4 clocks per bit,
//   4-entry FIFO) driven with the same stimulus. Each output is compared
//   every cycle against a frame/queue reference model.
module tb_uart_tx_fifo_engine;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int NI    = 4;
  localparam int DB [NI] = '{8, 8, 8, 7};
  localparam int PE [NI] = '{0, 1, 1, 0};
  localparam int PO [NI] = '{0, 0, 1, 0};
  localparam int SB [NI] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       flush = 1'b0;
  logic       clr_ovf = 1'b0;

  logic [NI-1:0] tx_o, busy_o, full_o, empty_o, ovf_o;
  logic [2:0]    cnt_o [NI];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue contents, remaining cycles of the frame on the
  // line, and that frame as a bit vector (start at index 0).
  int          m_qn    [NI];
  logic [7:0]  m_qd    [NI][DEPTH];
  int          m_rem   [NI];
  int          m_len   [NI];
  logic [15:0] m_frame [NI];
  logic        m_ovf   [NI];

  always #5 clk = ~clk;

  uart_tx_fifo_engine #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .DATA_BITS(8), .FIFO_DEPTH(4),
                        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_flush(flush), .i_clr_overflow(clr_ovf), .o_tx(tx_o[0]), .o_busy(busy_o[0]),
    .o_full(full_o[0]), .o_empty(empty_o[0]), .o_count(cnt_o[0]), .o_overflow(ovf_o[0]));

  uart_tx_fifo_engine #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .DATA_BITS(8), .FIFO_DEPTH(4),
                        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_flush(flush), .i_clr_overflow(clr_ovf), .o_tx(tx_o[1]), .o_busy(busy_o[1]),
    .o_full(full_o[1]), .o_empty(empty_o[1]), .o_count(cnt_o[1]), .o_overflow(ovf_o[1]));

  uart_tx_fifo_engine #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .DATA_BITS(8), .FIFO_DEPTH(4),
                        .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_flush(flush), .i_clr_overflow(clr_ovf), .o_tx(tx_o[2]), .o_busy(busy_o[2]),
    .o_full(full_o[2]), .o_empty(empty_o[2]), .o_count(cnt_o[2]), .o_overflow(ovf_o[2]));

  uart_tx_fifo_engine #(.CLK_FREQ_HZ(40), .BAUD_RATE(10), .DATA_BITS(7), .FIFO_DEPTH(4),
                        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset_n(reset_n), .i_wr_en(wr_en), .i_wr_data(wr_data[6:0]),
    .i_flush(flush), .i_clr_overflow(clr_ovf), .o_tx(tx_o[3]), .o_busy(busy_o[3]),
    .o_full(full_o[3]), .o_empty(empty_o[3]), .o_count(cnt_o[3]), .o_overflow(ovf_o[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_bits(input int k, input logic [7:0] d);
    logic [15:0] f;
    int ones;
    f    = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DB[k]; i++) begin
      f[1 + i] = d[i];
      ones += int'(d[i]);
    end
    if (PE[k] != 0) f[1 + DB[k]] = (PO[k] != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
    return f;
  endfunction

  function automatic int bit_pos(input int k);
    return (m_len[k] * CPB - m_rem[k]) / CPB;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_qn[k]    = 0;
      m_rem[k]   = 0;
      m_len[k]   = 0;
      m_frame[k] = '1;
      m_ovf[k]   = 1'b0;
    end
  endtask

  // Advances the model across one rising edge using the inputs held before it.
  task automatic model_step();
    int   n0;
    logic ev;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NI; k++) begin
      n0 = m_qn[k];
      if (m_rem[k] > 0) m_rem[k]--;
      if (m_rem[k] == 0 && m_qn[k] > 0) begin
        m_frame[k] = frame_bits(k, m_qd[k][0]);
        m_len[k]   = 1 + DB[k] + PE[k] + SB[k];
        m_rem[k]   = m_len[k] * CPB;
        for (int i = 0; i < DEPTH - 1; i++) m_qd[k][i] = m_qd[k][i + 1];
        m_qn[k]--;
      end
      ev = wr_en && (n0 == DEPTH);
      if (flush) m_qn[k] = 0;
      else if (wr_en && n0 < DEPTH) begin
        m_qd[k][m_qn[k]] = wr_data & 8'((1 << DB[k]) - 1);
        m_qn[k]++;
      end
      if (ev) m_ovf[k] = 1'b1;
      else if (clr_ovf) m_ovf[k] = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic exp_tx;
    for (int k = 0; k < NI; k++) begin
      exp_tx = (m_rem[k] > 0) ? m_frame[k][bit_pos(k)] : 1'b1;
      check($sformatf("tx%0d", k),    32'(tx_o[k]),    32'(exp_tx));
      check($sformatf("busy%0d", k),  32'(busy_o[k]),  32'(m_rem[k] > 0));
      check($sformatf("count%0d", k), 32'(cnt_o[k]),   32'(m_qn[k]));
      check($sformatf("full%0d", k),  32'(full_o[k]),  32'(m_qn[k] == DEPTH));
      check($sformatf("empty%0d", k), 32'(empty_o[k]), 32'(m_qn[k] == 0));
      check($sformatf("ovf%0d", k),   32'(ovf_o[k]),   32'(m_ovf[k]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  initial begin
    bit found;
    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(3);

    // single frame
    wr(8'hA5);
    idle(60);

    // burst into a 4-deep FIFO: one popped, four queued, one dropped
    for (int i = 1; i <= 6; i++) wr(8'(i));
    idle(20);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    idle(260);

    // parity cases and 7-bit/2-stop back-to-back frames
    wr(8'h07);
    idle(60);
    wr(8'h03);
    idle(60);
    wr(8'h7F);
    wr(8'h00);
    idle(110);

    // flush during frame 1 data phase
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    idle(14);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle(70);

    // overflow set and clear in the same cycle: set wins
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    wr_en   = 1'b1;
    clr_ovf = 1'b1;
    cycle();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    idle(260);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_data = 8'($urandom);
      flush   = ($urandom_range(0, 99) == 0);
      clr_ovf = ($urandom_range(0, 49) == 0);
      cycle();
    end
    wr_en   = 1'b0;
    flush   = 1'b0;
    clr_ovf = 1'b0;
    idle(260);

    // asynchronous reset while a low data bit is on the line
    wr(8'h00);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      cycle();
      if (m_rem[0] > 0 && bit_pos(0) >= 1 && bit_pos(0) <= 8 && tx_o[0] == 1'b0) found = 1'b1;
    end
    check("reset_window_found", 32'(found), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_tx%0d", k),    32'(tx_o[k]),    32'd1);
      check($sformatf("rst_busy%0d", k),  32'(busy_o[k]),  32'd0);
      check($sformatf("rst_count%0d", k), 32'(cnt_o[k]),   32'd0);
      check($sformatf("rst_full%0d", k),  32'(full_o[k]),  32'd0);
      check($sformatf("rst_empty%0d", k), 32'(empty_o[k]), 32'd1);
      check($sformatf("rst_ovf%0d", k),   32'(ovf_o[k]),   32'd0);
    end
    idle(2);
    reset_n = 1'b1;
    idle(2);
    wr(8'h5A);
    idle(60);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
